// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline stages.
//   - Bit positions inside the decoded control bundle.
//   - Default control bundle width.
//   - Encoding of the per-edge action taken by the ID/EX register.
package riscv_pipe_pkg;

  localparam int unsigned DEFAULT_CTRL_WIDTH = 8;

  localparam int unsigned CTRL_MEM_READ   = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_REG_WRITE  = 2;
  localparam int unsigned CTRL_BRANCH     = 3;
  localparam int unsigned CTRL_JUMP       = 4;
  localparam int unsigned CTRL_ALU_SRC    = 5;
  localparam int unsigned CTRL_MEM_TO_REG = 6;

  // What the ID/EX register does on the next clock edge, highest priority first.
  typedef enum logic [2:0] {
    ActReset,
    ActFlush,
    ActLoad,
    ActBubble,
    ActHold
  } idex_action_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   i_ex_valid, i_ex_ctrl, i_ex_rd : instruction currently held in EX
//   i_id_valid, i_id_uses_rs1/2,
//   i_id_rs1/2                     : instruction presented by decode
//   o_hazard                       : decode reads the destination of a load still in EX
module load_use_detect
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH    = DEFAULT_CTRL_WIDTH
) (
  input  logic                     i_ex_valid,
  input  logic [CTRL_WIDTH-1:0]    i_ex_ctrl,
  input  logic [ADDRESS_WIDTH-1:0] i_ex_rd,
  input  logic                     i_id_valid,
  input  logic                     i_id_uses_rs1,
  input  logic                     i_id_uses_rs2,
  input  logic [ADDRESS_WIDTH-1:0] i_id_rs1,
  input  logic [ADDRESS_WIDTH-1:0] i_id_rs2,
  output logic                     o_hazard
);

  logic w_ex_is_load;
  logic w_src_match;

  // A load to x0 produces nothing anyone can depend on.
  assign w_ex_is_load = i_ex_valid && i_ex_ctrl[CTRL_MEM_READ] && (i_ex_rd != '0);
  assign w_src_match  = (i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                        (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd));
  assign o_hazard     = w_ex_is_load && i_id_valid && w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures decoded fields and register file read data, stalls decode for one
// bubble on load-use hazards, refreshes held source operands from write-back
// while EX is back-pressured, and counts load-use bubbles (saturating).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : instruction from decode plus register file read data
//   id_ready          : decode instruction accepted this cycle (combinational)
//   flush             : kill the instruction held in EX
//   wb_we/wb_rd/wb_data : write-back bus (same as register file write port)
//   ex_ready          : EX consumes ex_* this cycle
//   ex_*              : registered instruction for EX, ex_valid marks it live
//   bubble_count      : saturating count of load-use bubbles
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH    = DEFAULT_CTRL_WIDTH,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [ADDRESS_WIDTH-1:0] id_rs1,
  input  logic [ADDRESS_WIDTH-1:0] id_rs2,
  input  logic [ADDRESS_WIDTH-1:0] id_rd,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [CTRL_WIDTH-1:0]    id_ctrl,
  input  logic                     flush,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     ex_ready,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [DATA_WIDTH-1:0]    ex_rs1_data,
  output logic [DATA_WIDTH-1:0]    ex_rs2_data,
  output logic [ADDRESS_WIDTH-1:0] ex_rs1,
  output logic [ADDRESS_WIDTH-1:0] ex_rs2,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic [CTRL_WIDTH-1:0]    ex_ctrl,
  output logic [CNT_WIDTH-1:0]     bubble_count
);

  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [ADDRESS_WIDTH-1:0] r_rs1;
  logic [ADDRESS_WIDTH-1:0] r_rs2;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [CTRL_WIDTH-1:0]    r_ctrl;
  logic [CNT_WIDTH-1:0]     r_bubble_count;

  logic         w_slot_free;
  logic         w_hazard;
  logic         w_wb_hit;
  idex_action_e w_action;

  load_use_detect #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .CTRL_WIDTH    (CTRL_WIDTH)
  ) u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_ctrl     (r_ctrl),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .o_hazard      (w_hazard)
  );

  assign w_slot_free = !r_valid || ex_ready;
  assign id_ready    = w_slot_free && !w_hazard && !flush;
  // Writes to x0 are ignored so a held x0 operand stays zero.
  assign w_wb_hit    = wb_we && (wb_rd != '0);

  always_comb begin
    w_action = ActHold;
    if (rst) begin
      w_action = ActReset;
    end else if (flush) begin
      w_action = ActFlush;
    end else if (w_slot_free && id_valid && !w_hazard) begin
      w_action = ActLoad;
    end else if (w_slot_free) begin
      w_action = ActBubble;
    end
  end

  always_ff @(posedge clk) begin
    case (w_action)
      ActReset, ActFlush: begin
        r_valid    <= 1'b0;
        r_pc       <= '0;
        r_imm      <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_ctrl     <= '0;
        if (w_action == ActReset) begin
          r_bubble_count <= '0;
        end
      end
      ActLoad: begin
        r_valid    <= 1'b1;
        r_pc       <= id_pc;
        r_imm      <= id_imm;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_rd       <= id_rd;
        r_ctrl     <= id_ctrl;
        // The register file does not hardwire x0, so zero it here.
        r_rs1_data <= (id_rs1 == '0) ? '0 : id_rs1_data;
        r_rs2_data <= (id_rs2 == '0) ? '0 : id_rs2_data;
      end
      ActBubble: begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        if (w_hazard && (r_bubble_count != {CNT_WIDTH{1'b1}})) begin
          r_bubble_count <= r_bubble_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ActHold: begin
        // Keep held operands current; rd is a destination and never refreshed.
        if (w_wb_hit && (wb_rd == r_rs1)) begin
          r_rs1_data <= wb_data;
        end
        if (w_wb_hit && (wb_rd == r_rs2)) begin
          r_rs2_data <= wb_data;
        end
      end
      default: begin
        r_valid <= r_valid;
      end
    endcase
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_imm       = r_imm;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_ctrl      = r_ctrl;
  assign bubble_count = r_bubble_count;

endmodule
